// File: rtl/uP_pkg.sv
// Shared definitions for the uP front end: instruction field map, opcode
// classes used by the decoder, and the fetch FSM state encoding.
package uP_pkg;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcode classes: ALU 0xxxxx, LOAD 10xxxx, STORE 11xxxx
    typedef enum logic [1:0] {
        OPC_ALU,
        OPC_LOAD,
        OPC_STORE
    } opc_class_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    function automatic opc_class_e opc_class(input logic [5:0] op);
        if (!op[5])     return OPC_ALU;
        else if (!op[4]) return OPC_LOAD;
        else             return OPC_STORE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO of {pc, word} with flush and occupancy.
// Head reads as zero when empty so downstream fields idle at 0.
module fetch_fifo #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    localparam int EW   = AW + DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] wdata,
    output logic [EW-1:0] rdata,
    output logic [CW-1:0] count
);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // Storage write; no reset needed since reads are gated by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; flush discards everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack, prefetch queue, redirect.
module fetch_unit
    import uP_pkg::*;
#(
    parameter int AW                  = 8,
    parameter int DW                  = 32,
    parameter int DEPTH               = 2,
    parameter int unsigned START_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redir,
    input  logic [AW-1:0] redir_addr,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] inst_pc,
    output logic [5:0]    op,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [15:0]   imm16
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state, state_nxt;
    logic [AW-1:0] pc, pc_nxt, drop_addr;
    logic          push, pop;
    logic [CW-1:0] count, count_after;
    logic [AW+DW-1:0] head;
    logic [DW-1:0] word;

    // Redirect wins over both queue ends: no push of the acked word, no pop
    assign push        = (state == REQ) && imem_ack && !redir;
    assign pop         = inst_valid && inst_ready && !redir;
    assign count_after = count + CW'(push) - CW'(pop);

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DROP) ? drop_addr : pc;

    // Next state and PC; a new request is only issued when a slot is free
    // for it, so a push can never land on a full queue
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: if (!redir && en && count < CW'(DEPTH)) state_nxt = REQ;
            REQ: begin
                if (redir)
                    state_nxt = imem_ack ? (en ? REQ : IDLE) : DROP;
                else if (imem_ack)
                    state_nxt = (en && count_after < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: if (imem_ack) state_nxt = en ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redir)     pc_nxt = redir_addr;
        else if (push) pc_nxt = pc + 1'b1;
    end

    // State, PC, and the stale address held while draining a dropped request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= AW'(START_ADDR);
            drop_addr <= AW'(START_ADDR);
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == REQ && redir && !imem_ack) drop_addr <= pc;
        end
    end

    fetch_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir),
        .push  (push),
        .pop   (pop),
        .wdata ({pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign inst_valid = (count != '0);
    assign inst_pc    = head[AW+DW-1:DW];
    assign word       = head[DW-1:0];
    assign op         = word[OP_MSB:OP_LSB];
    assign rs         = word[RS_MSB:RS_LSB];
    assign rt         = word[RT_MSB:RT_LSB];
    assign rd         = word[RD_MSB:RD_LSB];
    assign imm16      = word[IMM_MSB:IMM_LSB];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end for the single-cycle uP. It is the producer side of the opcode stream that the control decoder consumes.
- Runs the PC and fetches words from instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch queue.
- Presents the head instruction, split into op/rs/rt/rd/imm16, with a valid/ready handshake toward decode.
- Supports a PC redirect (jump/branch) that flushes in-flight work.

Parameters:
- AW, 8: instruction address width (word addressed); PC wraps mod 2^AW.
- DW, 32: instruction width; fixed field map below.
- DEPTH, 2: prefetch queue entries; power of 2, ≥2.
- START_ADDR, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; 0 = issue no new requests.
- imem_req  out  1  memory request; held until ack.
- imem_addr  out  AW  request address; stable while imem_req=1.
- imem_ack  in  1  transfer completes in any cycle with req=1 and ack=1.
- imem_rdata  in  DW  instruction word; valid when ack=1.
- redir  in  1  one-cycle redirect pulse.
- redir_addr  in  AW  new PC, sampled when redir=1.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head; pop on valid&ready.
- inst_pc  out  AW  address of head instruction.
- op  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- imm16  out  16  head[15:0].

Behaviour:
- Reset: asynchronous, applied immediately, including mid-transaction.
  - pc=START_ADDR, imem_addr=START_ADDR, imem_req=0, queue empty, inst_valid=0.
  - inst_pc and all field outputs are 0; FSM=IDLE.
- FSM states:
  - IDLE → REQ when en=1 and count+pending<DEPTH.
  - REQ: imem_req=1, imem_addr=pc.
    - On ack: push {pc, rdata}, pc<=pc+1.
    - Stay in REQ if en=1 and space remains after the push; otherwise go to IDLE.
    - Back-to-back requests are allowed; the new address appears the cycle after ack.
  - DROP: imem_req=1 with the stale address held. On ack, discard the data and go to REQ (or IDLE if en=0) using the redirected pc.
- At most one outstanding request. pending = (state≠IDLE).
- Space rule guarantees a push never hits a full queue. A push into a queue that is popping in the same cycle is legal.
- Latency: ack in cycle N → inst_valid=1 in cycle N+1 if the queue was empty.
- Outputs are driven from the queue head. Head fields are stable while inst_valid=1 and inst_ready=0.
- Pop and push in the same cycle: count unchanged; order preserved (FIFO).
- en deasserted during REQ: the current transaction completes and is buffered; no further requests.
- Redirect (highest priority):
  - Queue flushed, so inst_valid=0 next cycle, and pc<=redir_addr.
  - A pop in the same cycle is ignored.
  - In REQ without ack that cycle → DROP. The handshake is never abandoned.
  - In REQ with ack that cycle → data discarded, next state REQ with address redir_addr.
  - In DROP → pc updated, remain in DROP.
  - In IDLE → pc updated only.
- Wrap-around: pc=2^AW−1 increments to 0, no flag.

Decomposition:
- Shared package uP_pkg holds:
  - field position constants: OP_MSB/LSB, RS_, RT_, RD_, IMM_;
  - opcode class constants shared with the decoder: ALU 0xxxxx, LOAD 10xxxx, STORE 11xxxx;
  - FSM state encoding: IDLE/REQ/DROP.
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO of {AW-bit pc, DW-bit word}, with flush, count, and the same clk/rst.

Test Plan:
- Basic fetch:
  - Stimulus: rst, then en=1, zero-wait ack, mem[0]=0x00221800, inst_ready=1.
  - Response: req in first cycle with addr=0; inst_valid next cycle with inst_pc=0, op=0, rs=1, rt=2, rd=3, imm16=0x1800; next req addr=1.
- Backpressure:
  - Stimulus: DEPTH=2, inst_ready=0.
  - Response: exactly two transfers (addr 0, 1), then imem_req=0 and pc=2.
  - Then pulse inst_ready one cycle → head becomes addr 1; req reissued with addr=2.
- Redirect during wait:
  - Stimulus: ack delayed 3 cycles on addr 5; redir with redir_addr=0x40 in the 1st wait cycle.
  - Response: req stays high at addr 5 until ack; that data never reaches inst_valid; next req addr=0x40; first valid inst_pc=0x40.
- Redirect coincident with ack:
  - Stimulus: redir=1 and imem_ack=1 in the same cycle, redir_addr=0x10.
  - Response: word dropped; queue empty next cycle; next req addr=0x10 with no DROP cycle.
- Wrap-around:
  - Stimulus: redir to 0xFF, sequential fetch.
  - Response: inst_pc sequence 0xFF, 0x00, 0x01.
- Async reset mid-transaction:
  - Stimulus: assert rst between clock edges while imem_req=1 and the queue holds 1 entry.
  - Response: imem_req=0 and inst_valid=0 immediately.
  - After release with en=1: first req addr=START_ADDR.
